// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply and restoring divide into MIPS-style HI/LO registers.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             ovf,
   output logic             dz
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_MINU,
      OP_MINS, OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO
   } op_t;

   state_t             state, state_nxt;
   op_t                op;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;      // MUL: partial product; DIV: {remainder, quotient}
   logic [2*WIDTH-1:0] mcand;    // MUL: shifted multiplicand; DIV: divisor in low half
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   hi, lo;

   logic               accept, start_mul, start_div, last_step;
   logic [WIDTH-1:0]   res, sum, diff;
   logic               res_ovf, res_dz;
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   div_rem, div_quo;

   assign op        = op_t'(sel);
   assign accept    = in_valid && in_ready;
   assign start_mul = accept && (op == OP_MULTU);
   assign start_div = accept && (op == OP_DIVU) && (in2 != '0);
   assign last_step = (count == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (start_mul) state_nxt = MUL;
                  else if (start_div) state_nxt = DIV;
         MUL, DIV: if (last_step) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
   end

   assign sum  = in1 + in2;
   assign diff = in1 - in2;

   always_comb begin
      res     = '0;
      res_ovf = 1'b0;
      res_dz  = 1'b0;
      case (op)
         OP_ADD: begin
            res     = sum;
            res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SUB: begin
            res     = diff;
            res_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_AND:   res = in1 & in2;
         OP_OR:    res = in1 | in2;
         OP_XOR:   res = in1 ^ in2;
         OP_NAND:  res = ~(in1 & in2);
         OP_NOR:   res = ~(in1 | in2);
         OP_MINU:  res = (in1 < in2) ? in1 : in2;
         OP_MINS:  res = ($signed(in1) < $signed(in2)) ? in1 : in2;
         OP_SLL:   res = in1 << in2[SHW-1:0];
         OP_SRL:   res = in1 >> in2[SHW-1:0];
         OP_SRA:   res = $unsigned($signed(in1) >>> in2[SHW-1:0]);
         OP_DIVU: begin
            // Only reaches the result register when the divisor is zero.
            res    = '1;
            res_dz = 1'b1;
         end
         OP_MFHI:  res = hi;
         OP_MFLO:  res = lo;
         default:  res = '0;
      endcase
   end

   // One shift-add multiply step and one restoring-divide step.
   assign mul_acc = acc + (mplier[0] ? mcand : '0);
   assign trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mcand[WIDTH-1:0]};
   assign div_rem = trial[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0];
   assign div_quo = {acc[WIDTH-2:0], ~trial[WIDTH]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         count     <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         hi        <= '0;
         lo        <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mul) begin
                  acc    <= '0;
                  mcand  <= {{WIDTH{1'b0}}, in1};
                  mplier <= in2;
                  count  <= CW'(WIDTH);
               end else if (start_div) begin
                  acc   <= {{WIDTH{1'b0}}, in1};
                  mcand <= {{WIDTH{1'b0}}, in2};
                  count <= CW'(WIDTH);
               end else if (accept) begin
                  out       <= res;
                  zero      <= (res == '0);
                  ovf       <= res_ovf;
                  dz        <= res_dz;
                  out_valid <= 1'b1;
                  if (op == OP_DIVU) begin
                     hi <= in1;
                     lo <= '1;
                  end
               end
            end
            MUL: begin
               acc    <= mul_acc;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - CW'(1);
               if (last_step) begin
                  {hi, lo}  <= mul_acc;
                  out       <= mul_acc[WIDTH-1:0];
                  zero      <= (mul_acc[WIDTH-1:0] == '0);
                  ovf       <= 1'b0;
                  dz        <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DIV: begin
               acc   <= {div_rem, div_quo};
               count <= count - CW'(1);
               if (last_step) begin
                  hi        <= div_rem;
                  lo        <= div_quo;
                  out       <= div_quo;
                  zero      <= (div_quo == '0);
                  ovf       <= 1'b0;
                  dz        <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq, checked against a plain-arithmetic
// reference model that tracks HI/LO.
module tb_alu_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   sel = '0;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic         out_valid;
   logic [W-1:0] out;
   logic         zero, ovf, dz;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   typedef struct packed {
      logic [W-1:0] out;
      logic         zero;
      logic         ovf;
      logic         dz;
   } res_t;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .in1(in1), .in2(in2), .out_valid(out_valid), .out(out),
      .zero(zero), .ovf(ovf), .dz(dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: 64-bit arithmetic on the architectural definitions.
   task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t e);
      longint sa, sb, r;
      logic [63:0] p;
      int sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % W);
      e  = '0;
      case (op)
         4'd0: begin r = sa + sb; e.out = r[W-1:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         4'd1: begin r = sa - sb; e.out = r[W-1:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         4'd2: e.out = a & b;
         4'd3: e.out = a | b;
         4'd4: e.out = a ^ b;
         4'd5: e.out = ~(a & b);
         4'd6: e.out = ~(a | b);
         4'd7: e.out = (a < b) ? a : b;
         4'd8: e.out = (sa < sb) ? a : b;
         4'd9:  e.out = a << sh;
         4'd10: e.out = a >> sh;
         4'd11: begin r = sa >>> sh; e.out = r[W-1:0]; end
         4'd12: begin
            p = 64'(a) * 64'(b);
            m_hi = p[63:32];
            m_lo = p[31:0];
            e.out = m_lo;
         end
         4'd13: begin
            if (b == 0) begin
               m_hi = a;
               m_lo = '1;
               e.dz = 1'b1;
            end else begin
               m_hi = a % b;
               m_lo = a / b;
            end
            e.out = m_lo;
         end
         4'd14: e.out = m_hi;
         default: e.out = m_lo;
      endcase
      e.zero = (e.out == 0);
   endtask

   // Issue one op, wait (bounded) for its result, then check result, latency and pulse width.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
      res_t e;
      int   lat;
      int   exp_lat;
      bit   ready_seen;
      model(op, a, b, e);
      exp_lat = (op == 4'd12 || (op == 4'd13 && b != 0)) ? W : 0;
      check({tag, "/ready_before"}, in_ready, 1);
      in_valid = 1'b1; sel = op; in1 = a; in2 = b;
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
      lat = 0;
      ready_seen = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check({tag, "/latency"}, lat, exp_lat);
      check({tag, "/out"}, out, e.out);
      check({tag, "/flags"}, {zero, ovf, dz}, {e.zero, e.ovf, e.dz});
      if (exp_lat != 0) begin
         check({tag, "/busy_ready"}, ready_seen, 0);
         check({tag, "/ready_at_result"}, in_ready, 1);
      end
      @(posedge clk); #1;
      check({tag, "/pulse"}, out_valid, 0);
   endtask

   initial begin
      res_t e;
      logic [3:0] op;
      logic [W-1:0] a, b;
      bit early;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset/state", {out_valid, in_ready, zero, ovf, dz}, 5'b01000);
      check("reset/out", out, 0);

      run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0);
      run_op("sub_zero", 4'd1, 32'd5, 32'd5, 0);
      run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 0);
      run_op("multu_max", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      run_op("mfhi_mul", 4'd14, 32'd0, 32'd0, 0);
      run_op("divu_100_7", 4'd13, 32'd100, 32'd7, 0);
      run_op("mfhi_div", 4'd14, 32'd0, 32'd0, 0);
      run_op("divu_by0", 4'd13, 32'd5, 32'd0, 0);
      run_op("mfhi_dz", 4'd14, 32'd0, 32'd0, 0);
      run_op("mflo_dz", 4'd15, 32'd0, 32'd0, 0);
      run_op("sra", 4'd11, 32'h8000_0000, 32'h24, 0);
      run_op("sll", 4'd9, 32'd1, 32'd31, 0);
      run_op("mins", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("minu", 4'd7, 32'hFFFF_FFFF, 32'd1, 0);

      for (int i = 0; i < 3; i++) begin
         run_op("multu_rand", 4'd12, $urandom, $urandom, 0);
         run_op("mfhi_rand", 4'd14, 32'd0, 32'd0, 0);
         run_op("divu_rand", 4'd13, $urandom, (i == 0) ? $urandom : $urandom_range(1, 1000), 0);
         run_op("mfhi_rand", 4'd14, 32'd0, 32'd0, 0);
      end

      // Reset in the middle of a multiply: no result, HI/LO cleared.
      in_valid = 1'b1; sel = 4'd12; in1 = 32'h1234_5678; in2 = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      early = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) early = 1'b1;
      end
      rst = 1'b1;
      #2;
      check("rst_mul/early", early, 0);
      check("rst_mul/valid", out_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      check("rst_mul/ready", in_ready, 1);
      early = 1'b0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (out_valid) early = 1'b1;
      end
      check("rst_mul/no_result", early, 0);
      run_op("rst_mflo", 4'd15, 32'd0, 32'd0, 0);
      run_op("rst_mfhi", 4'd14, 32'd0, 32'd0, 0);
      run_op("rst_add", 4'd0, 32'd2, 32'd3, 0);

      // Streaming single-cycle ops on consecutive cycles.
      run_op("stream_seed", 4'd12, $urandom, $urandom, 0);
      for (int i = 0; i < 16; i++) begin
         op = 4'($urandom_range(0, 13));
         if (op >= 4'd12) op = op + 4'd2;
         a = $urandom;
         b = (i % 4 == 0) ? a : $urandom;
         model(op, a, b, e);
         in_valid = 1'b1; sel = op; in1 = a; in2 = b;
         @(posedge clk); #1;
         check($sformatf("stream%0d/valid", i), out_valid, 1);
         check($sformatf("stream%0d/out op%0d", i, op), out, e.out);
         check($sformatf("stream%0d/flags", i), {zero, ovf, dz}, {e.zero, e.ovf, e.dz});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("stream/pulse_end", out_valid, 0);
      run_op("stream_mfhi", 4'd14, 32'd0, 32'd0, 0);
      run_op("stream_mflo", 4'd15, 32'd0, 32'd0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
